main_memory_responder: RTL
==========================

// Module: main_memory_responder
// PURPOSE
//  Backing main memory answering the L1 cache's miss fills and write-backs: the memory-side end of the cache/memory interface.
//  Accepts one request at a time over a valid/ready handshake, models a fixed access latency and returns a single-cycle response.
//  Supports combined write-back+fill (dirty victim evicted, new line fetched) as one transaction.
// PARAMETERS
//  ADDR_W   10  word address width = {tag[7:0], index[1:0]}
//  DATA_W   8   data word width (one word per cache line)
//  LATENCY  4   cycles per memory access, legal range 1..15
// PORTS
//  clock        in   1       single clock, all logic on posedge
//  reset_n      in   1       synchronous, active-low reset
//  req_valid    in   1       cache presents a request
//  req_ready    out  1       responder can accept (IDLE only)
//  req_op       in   2       00 READ, 01 WRITE, 10 WB_FILL, 11 reserved
//  req_addr     in   ADDR_W  read/fill address (WRITE: write address)
//  req_wb_addr  in   ADDR_W  victim address, used by WB_FILL only
//  req_wdata    in   DATA_W  write / victim data
//  resp_valid   out  1       one-cycle response pulse, no backpressure
//  resp_data    out  DATA_W  read data (READ/WB_FILL); echo of written data (WRITE)
//  resp_err     out  1       high with resp_valid when op was reserved 11
// BEHAVIOUR
//  Reset: state<=INIT, sweep ptr<=0, req_ready=0, resp_valid=0, resp_data=0, resp_err=0; in-flight op aborted, no response.
//  FSM: INIT -> IDLE -> {RD, WR, WB} -> RESP -> IDLE.
//   INIT: writes mem[ptr]=ptr[DATA_W-1:0], one word/cycle; after ptr=2^ADDR_W-1 -> IDLE (1024 cycles at defaults).
//   IDLE: req_ready=1; on req_valid&&req_ready latch op/addr/wb_addr/wdata, load latency counter = LATENCY-1.
//    READ/11 -> RD; WRITE -> WR; WB_FILL -> WB.
//   WB: count to 0; on terminal cycle commit mem[wb_addr]=wdata, reload counter, -> RD.
//   WR: count to 0; on terminal cycle commit mem[addr]=wdata, resp_data<=wdata -> RESP.
//   RD: count to 0; on terminal cycle resp_data<=mem[addr] -> RESP.
//   RESP: resp_valid=1 for exactly one cycle (resp_err=1 iff op was 11, served as READ) -> IDLE.
//  Latency: acceptance edge k; resp_valid high in cycle after edge k+LATENCY (READ/WRITE), k+2*LATENCY (WB_FILL).
//  Throughput: req_ready low from acceptance through RESP; next accept earliest in cycle after RESP.
//  resp_data holds last response value between pulses; resp_err cleared when resp_valid drops.
//  WB_FILL with wb_addr==addr: write commits first, fill returns the just-written wdata.
//  Requests during INIT/busy are ignored (not queued); cache must hold req_valid until req_ready.
//  Reset mid-op: uncommitted write discarded; memory reinitialised by INIT sweep regardless.
//  Address/counter arithmetic unsigned, counter width 4 bits; sweep ptr ADDR_W+1 bits to detect wrap.
// STRUCTURE
//  mem_defs.vh: OP_READ/OP_WRITE/OP_WB_FILL/OP_RSVD codes, state encodings, default ADDR_W/DATA_W.
//  Sub-module mem_array: single-port synchronous RAM (2^ADDR_W x DATA_W, one write or read per cycle).
//  Top holds FSM, latency counter, request latch, INIT sweep mux on RAM port.
// TESTING
//  Reset then wait: req_ready stays 0 for 1024 cycles, rises after; READ addr 0x3C7 -> resp_data=0xC7.
//  WRITE addr 0x003 data 0xFF, LATENCY=4 -> resp_valid 4 cycles post-accept, data 0xFF; READ 0x003 -> 0xFF.
//  WB_FILL wb_addr 0x003 data 0x01, addr 0x01E -> resp at 8 cycles, data 0x1E; READ 0x003 -> 0x01.
//  WB_FILL wb_addr=addr=0x01F data 0x0A -> resp_data 0x0A.
//  op=11 addr 0x010 -> resp_valid with resp_err=1, resp_data 0x10; next READ resp_err=0.
//  reset_n low 1 cycle mid-WRITE (before commit) addr 0x005 data 0x99 -> no resp; after INIT READ 0x005 -> 0x05.

Source files
------------

// File: rtl/main_memory_responder_pkg.sv
// Shared definitions for the main memory responder: opcodes, FSM states and default geometry.
package main_memory_responder_pkg;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_LATENCY = 4;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_WB_FILL = 2'b10;
    localparam logic [1:0] OP_RSVD    = 2'b11;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_WB   = 3'd4,
        ST_RESP = 3'd5
    } state_t;

    // The reserved opcode is served as a read but flagged on the response.
    function automatic logic is_rsvd(input logic [1:0] op);
        return (op == OP_RSVD);
    endfunction

endpackage

// File: rtl/main_memory_responder_mem_array.sv
// Single-port RAM, 2^ADDR_W x DATA_W: clocked write, read data follows the address.
module main_memory_responder_mem_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              i_clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Storage write port.
    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else begin
            r_mem[i_addr] <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/main_memory_responder.sv
// Memory-side responder for L1 fills and write-backs: INIT sweep, fixed-latency access FSM,
// one-cycle response pulse.
module main_memory_responder
    import main_memory_responder_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_wb_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err
);

    localparam logic [3:0] LAT_RELOAD = 4'(LATENCY - 1);

    state_t            r_state;
    logic [ADDR_W:0]   r_ptr;
    logic [3:0]        r_cnt;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_cnt_done;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;

    assign w_cnt_done = (r_cnt == 4'd0);

    // RAM port steering; writes are gated by reset so an aborted op never commits.
    always_comb begin
        w_we    = 1'b0;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        case (r_state)
            ST_INIT: begin
                w_we    = reset_n;
                w_addr  = r_ptr[ADDR_W-1:0];
                w_wdata = r_ptr[DATA_W-1:0];
            end
            ST_WB: begin
                if (w_cnt_done) begin
                    w_we   = reset_n;
                    w_addr = r_wb_addr;
                end else begin
                    w_we   = 1'b0;
                    w_addr = r_addr;
                end
            end
            ST_WR: begin
                if (w_cnt_done) begin
                    w_we = reset_n;
                end else begin
                    w_we = 1'b0;
                end
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    main_memory_responder_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .i_clock (clock),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // Request FSM with latency counter, request latch and registered response outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= ST_INIT;
            r_ptr      <= '0;
            r_cnt      <= 4'd0;
            r_op       <= OP_READ;
            r_addr     <= '0;
            r_wb_addr  <= '0;
            r_wdata    <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_ptr <= r_ptr + {{ADDR_W{1'b0}}, 1'b1};
                    if (r_ptr[ADDR_W-1:0] == {ADDR_W{1'b1}}) begin
                        r_state   <= ST_IDLE;
                        req_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_op      <= req_op;
                        r_addr    <= req_addr;
                        r_wb_addr <= req_wb_addr;
                        r_wdata   <= req_wdata;
                        r_cnt     <= LAT_RELOAD;
                        req_ready <= 1'b0;
                        case (req_op)
                            OP_WRITE:   r_state <= ST_WR;
                            OP_WB_FILL: r_state <= ST_WB;
                            default:    r_state <= ST_RD;
                        endcase
                    end
                end
                ST_WB: begin
                    // Victim commits here; the fill then runs a full second latency.
                    if (w_cnt_done) begin
                        r_cnt   <= LAT_RELOAD;
                        r_state <= ST_RD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_WR: begin
                    if (w_cnt_done) begin
                        resp_data  <= r_wdata;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        r_state    <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RD: begin
                    if (w_cnt_done) begin
                        resp_data  <= w_rdata;
                        resp_valid <= 1'b1;
                        resp_err   <= is_rsvd(r_op);
                        r_state    <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_INIT;
                    r_ptr      <= '0;
                    req_ready  <= 1'b0;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
